// File: rtl/stream_fifo_frame_reader_pkg.sv
// Shared types and helpers for the stream FIFO frame reader.
package stream_fifo_pkg;

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_BODY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Header counter width: max(1, clog2(headsize)).
  function automatic int hcnt_width(input int headsize);
    int w;
    w = $clog2(headsize);
    return (w < 1) ? 1 : w;
  endfunction

  // Length field of the last header word: the low lenw bits, zero-extended.
  function automatic logic [63:0] len_field(input logic [63:0] word, input int lenw);
    logic [63:0] mask;
    mask = (64'd1 << lenw) - 64'd1;
    return word & mask;
  endfunction

endpackage

// File: rtl/stream_fifo_frame_reader_out_reg.sv
// Single-entry valid/ready output register carrying data, sop and eop.
module stream_out_reg #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 flush,
  output logic                 ready_for_load,
  input  logic [DATAWIDTH-1:0] d_data,
  input  logic                 d_sop,
  input  logic                 d_eop,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_sop,
  output logic                 m_eop
);

  // Slot is free when empty or being drained this cycle.
  assign ready_for_load = ~m_valid | m_ready;

  // Flush wins over load; without a load an accepted word empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= d_data;
      m_sop   <= d_sop;
      m_eop   <= d_eop;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_fifo_frame_reader.sv
// Frame de-framer on the FWFT read port of the stream FIFO controller.
//   state   | meaning
//   ST_HEAD | popping header words, last one loads length
//   ST_BODY | popping payload words into the output register
//   ST_ERR  | FIFO error seen, waiting for r_error to drop
module stream_fifo_frame_reader
  import stream_fifo_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int HEADSIZE  = 1,
  parameter int LENWIDTH  = 12,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 r_valid,
  output logic                 r_en,
  input  logic [DATAWIDTH-1:0] r_data,
  input  logic                 r_error,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_sop,
  output logic                 m_eop,
  output logic [DATAWIDTH-1:0] m_hdr,
  output logic                 err_len,
  output logic                 err_fifo,
  output logic [CNTWIDTH-1:0]  frame_cnt
);

  localparam int               HCNTW = hcnt_width(HEADSIZE);
  localparam logic [HCNTW-1:0] HLAST = HCNTW'(HEADSIZE - 1);

  state_t              state, state_nxt;
  logic [HCNTW-1:0]    hcnt;
  logic [LENWIDTH-1:0] remaining;
  logic [LENWIDTH-1:0] len;
  logic                sop_pending;
  logic                hdr_pop, hdr_last, body_pop, ld_rdy;

  assign len      = LENWIDTH'(len_field(64'(r_data), LENWIDTH));
  assign hdr_last = hdr_pop && (hcnt == HLAST);

  // Next state and FIFO pop; r_error suppresses any pop in its cycle.
  always_comb begin
    state_nxt = state;
    r_en      = 1'b0;
    hdr_pop   = 1'b0;
    body_pop  = 1'b0;
    if (r_error) begin
      state_nxt = ST_ERR;
    end else begin
      case (state)
        ST_HEAD: begin
          r_en    = r_valid;
          hdr_pop = r_valid;
          if (r_valid && (hcnt == HLAST))
            state_nxt = (len == '0) ? ST_HEAD : ST_BODY;
        end
        ST_BODY: begin
          r_en     = r_valid & ld_rdy;
          body_pop = r_valid & ld_rdy;
          if (body_pop && (remaining == LENWIDTH'(1)))
            state_nxt = ST_HEAD;
        end
        ST_ERR:  state_nxt = ST_HEAD;
        default: state_nxt = ST_HEAD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HEAD;
    else        state <= state_nxt;
  end

  // Header counter, length, sop flag, captured header and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      remaining   <= '0;
      sop_pending <= 1'b0;
      m_hdr       <= '0;
      err_len     <= 1'b0;
      err_fifo    <= 1'b0;
    end else begin
      err_len  <= hdr_last && (len == '0);
      err_fifo <= r_error && (state != ST_ERR);
      if (state == ST_ERR) begin
        hcnt        <= '0;
        sop_pending <= 1'b0;
      end else if (hdr_last) begin
        hcnt        <= '0;
        m_hdr       <= r_data;
        remaining   <= len;
        sop_pending <= 1'b1;
      end else if (hdr_pop) begin
        hcnt <= hcnt + 1'b1;
      end else if (body_pop) begin
        remaining   <= remaining - 1'b1;
        sop_pending <= 1'b0;
      end
    end
  end

  // Completed frames: counted when the eop word is accepted, even during r_error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         frame_cnt <= '0;
    else if (m_valid && m_ready && m_eop) frame_cnt <= frame_cnt + 1'b1;
  end

  stream_out_reg #(.DATAWIDTH(DATAWIDTH)) u_out (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (body_pop),
    .flush          (r_error),
    .ready_for_load (ld_rdy),
    .d_data         (r_data),
    .d_sop          (sop_pending),
    .d_eop          (remaining == LENWIDTH'(1)),
    .m_ready        (m_ready),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_sop          (m_sop),
    .m_eop          (m_eop)
  );

endmodule

// File: tb/tb_stream_fifo_frame_reader.sv
// Directed bench for stream_fifo_frame_reader with HEADSIZE=1.
module tb_stream_fifo_frame_reader;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r_valid = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic          r_error = 1'b0;
  logic          m_ready = 1'b1;
  logic          r_en, m_valid, m_sop, m_eop, err_len, err_fifo;
  logic [DW-1:0] m_data, m_hdr;
  logic [CW-1:0] frame_cnt;

  logic [DW-1:0] q[$];
  int n_cmp = 0;
  int n_err = 0;

  stream_fifo_frame_reader #(
    .DATAWIDTH(DW), .HEADSIZE(1), .LENWIDTH(12), .CNTWIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .r_valid(r_valid), .r_en(r_en), .r_data(r_data),
    .r_error(r_error), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .m_hdr(m_hdr), .err_len(err_len),
    .err_fifo(err_fifo), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    r_valid = (q.size() != 0);
    r_data  = (q.size() != 0) ? q[0] : '0;
    #1;
  endtask

  task automatic cyc();
    logic p;
    #1;
    p = r_en;
    @(posedge clk);
    #1;
    if (p && q.size() != 0) void'(q.pop_front());
    drive();
  endtask

  task automatic out(input string tag, input logic v, input logic [DW-1:0] d,
                     input logic s, input logic e);
    chk({tag, ".valid"}, 64'(m_valid), 64'(v));
    chk({tag, ".data"},  64'(m_data),  64'(d));
    chk({tag, ".sop"},   64'(m_sop),   64'(s));
    chk({tag, ".eop"},   64'(m_eop),   64'(e));
  endtask

  initial begin
    // reset values
    #12;
    chk("rst.m_valid", 64'(m_valid), 0);
    chk("rst.r_en", 64'(r_en), 0);
    chk("rst.m_data", 64'(m_data), 0);
    chk("rst.m_hdr", 64'(m_hdr), 0);
    chk("rst.frame_cnt", 64'(frame_cnt), 0);
    chk("rst.err_len", 64'(err_len), 0);
    chk("rst.err_fifo", 64'(err_fifo), 0);
    rst_n = 1'b1;

    // frame 1: header 3, payload A0,B0,C0
    q.push_back(32'h003); q.push_back(32'hA0); q.push_back(32'hB0); q.push_back(32'hC0);
    drive();
    chk("f1.r_en_head", 64'(r_en), 1);
    cyc();
    chk("f1.m_hdr", 64'(m_hdr), 64'h3);
    chk("f1.gap_valid", 64'(m_valid), 0);
    cyc(); out("f1.w0", 1'b1, 32'hA0, 1'b1, 1'b0);
    cyc(); out("f1.w1", 1'b1, 32'hB0, 1'b0, 1'b0);
    cyc(); out("f1.w2", 1'b1, 32'hC0, 1'b0, 1'b1);
    chk("f1.cnt_before", 64'(frame_cnt), 0);
    cyc();
    chk("f1.cnt_after", 64'(frame_cnt), 1);
    chk("f1.idle_valid", 64'(m_valid), 0);

    // back-to-back frames of length 1 and 2
    q.push_back(32'h001); q.push_back(32'hD1);
    q.push_back(32'h002); q.push_back(32'hE1); q.push_back(32'hE2);
    drive();
    cyc(); chk("f2.m_hdr", 64'(m_hdr), 64'h1);
    cyc(); out("f2.w0", 1'b1, 32'hD1, 1'b1, 1'b1);
    cyc();
    chk("f3.gap_valid", 64'(m_valid), 0);
    chk("f3.m_hdr", 64'(m_hdr), 64'h2);
    chk("f2.cnt", 64'(frame_cnt), 2);
    cyc(); out("f3.w0", 1'b1, 32'hE1, 1'b1, 1'b0);
    cyc(); out("f3.w1", 1'b1, 32'hE2, 1'b0, 1'b1);
    cyc(); chk("f3.cnt", 64'(frame_cnt), 3);

    // zero-length header then length-2 frame
    q.push_back(32'h000); q.push_back(32'h002); q.push_back(32'hF1); q.push_back(32'hF2);
    drive();
    cyc();
    chk("zl.err_len", 64'(err_len), 1);
    chk("zl.m_valid", 64'(m_valid), 0);
    chk("zl.m_hdr", 64'(m_hdr), 0);
    cyc();
    chk("zl.err_len_clr", 64'(err_len), 0);
    chk("zl.m_valid2", 64'(m_valid), 0);
    chk("zl.m_hdr2", 64'(m_hdr), 64'h2);
    cyc(); out("f4.w0", 1'b1, 32'hF1, 1'b1, 1'b0);
    cyc(); out("f4.w1", 1'b1, 32'hF2, 1'b0, 1'b1);
    cyc(); chk("f4.cnt", 64'(frame_cnt), 4);

    // backpressure: length 4, m_ready low for 3 cycles after first word
    q.push_back(32'h004); q.push_back(32'h61); q.push_back(32'h62);
    q.push_back(32'h63); q.push_back(32'h64);
    drive();
    cyc();
    cyc(); out("bp.w0", 1'b1, 32'h61, 1'b1, 1'b0);
    m_ready = 1'b0;
    #1;
    chk("bp.r_en_hold", 64'(r_en), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      out("bp.held", 1'b1, 32'h61, 1'b1, 1'b0);
      chk("bp.r_en_held", 64'(r_en), 0);
    end
    m_ready = 1'b1;
    #1;
    chk("bp.r_en_go", 64'(r_en), 1);
    cyc(); out("bp.w1", 1'b1, 32'h62, 1'b0, 1'b0);
    cyc(); out("bp.w2", 1'b1, 32'h63, 1'b0, 1'b0);
    cyc(); out("bp.w3", 1'b1, 32'h64, 1'b0, 1'b1);
    cyc(); chk("bp.cnt", 64'(frame_cnt), 5);

    // r_error after 2 of 5 payload words
    q.push_back(32'h005); q.push_back(32'h71); q.push_back(32'h72);
    q.push_back(32'h73); q.push_back(32'h74); q.push_back(32'h75);
    drive();
    cyc();
    cyc(); out("er.w0", 1'b1, 32'h71, 1'b1, 1'b0);
    cyc(); out("er.w1", 1'b1, 32'h72, 1'b0, 1'b0);
    r_error = 1'b1;
    #1;
    chk("er.r_en_forced", 64'(r_en), 0);
    cyc();
    chk("er.err_fifo", 64'(err_fifo), 1);
    chk("er.m_valid", 64'(m_valid), 0);
    chk("er.r_en_err", 64'(r_en), 0);
    cyc();
    chk("er.err_fifo_once", 64'(err_fifo), 0);
    chk("er.r_en_err2", 64'(r_en), 0);
    r_error = 1'b0;
    q.delete();
    q.push_back(32'h001); q.push_back(32'h81);
    drive();
    chk("er.r_en_leave", 64'(r_en), 0);
    cyc();
    chk("er.cnt_unchanged", 64'(frame_cnt), 5);
    chk("er.r_en_head", 64'(r_en), 1);
    cyc(); chk("er.m_hdr", 64'(m_hdr), 64'h1);
    cyc(); out("er.next", 1'b1, 32'h81, 1'b1, 1'b1);
    cyc(); chk("er.cnt_next", 64'(frame_cnt), 6);

    // asynchronous reset mid-frame
    q.push_back(32'h003); q.push_back(32'h91); q.push_back(32'h92); q.push_back(32'h93);
    drive();
    cyc();
    cyc(); out("ar.w0", 1'b1, 32'h91, 1'b1, 1'b0);
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar.m_valid", 64'(m_valid), 0);
    chk("ar.m_data", 64'(m_data), 0);
    chk("ar.frame_cnt", 64'(frame_cnt), 0);
    chk("ar.m_hdr", 64'(m_hdr), 0);
    q.delete();
    drive();
    rst_n = 1'b1;
    m_ready = 1'b1;
    q.push_back(32'h002); q.push_back(32'hA1); q.push_back(32'hA2);
    drive();
    cyc();
    chk("ar.head_m_hdr", 64'(m_hdr), 64'h2);
    chk("ar.head_valid", 64'(m_valid), 0);
    cyc(); out("ar.w0b", 1'b1, 32'hA1, 1'b1, 1'b0);
    cyc(); out("ar.w1b", 1'b1, 32'hA2, 1'b0, 1'b1);
    cyc(); chk("ar.cnt", 64'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
